// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR word generator.
//   Produces one registered WIDTH-bit word per advance (STEPS shifts per word),
//   held in a one-deep valid/ready output register. Seeds can be loaded at
//   runtime; an all-zero state is replaced by 1 and flagged. Advances between
//   returns to the reference seed are counted and reported as the period.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-low reset
//   i_en         request a new word
//   i_load       load i_load_data as state and reference seed (beats i_en)
//   i_load_data  seed value
//   o_out_data   registered sequence word
//   o_out_valid  o_out_data holds an unconsumed word
//   i_out_ready  consumer accepts o_out_data
//   o_wrap       1-cycle strobe: sequence returned to the reference seed
//   o_lockup     1-cycle strobe: zero state replaced by 1
//   o_period     advances between the last two wraps
module lfsr_gen #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] TAPS  = 32'h0000_B400,
  parameter logic [31:0] SEED  = 32'd1,
  parameter int          STEPS = 1,
  parameter int          MODE  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_wrap,
  output logic             o_lockup,
  output logic [31:0]      o_period
);

  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_R = (SEED[WIDTH-1:0] == '0) ? ONE : SEED[WIDTH-1:0];

  // Single shift in the selected form.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    if (MODE == 0) return {s[WIDTH-2:0], ^(s & TAP_M)};
    else           return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? {TAP_M[WIDTH-2:0], 1'b1} : '0);
  endfunction

  logic [WIDTH-1:0] r_state, r_ref, r_out;
  logic             r_vld, r_wrap, r_lock;
  logic [31:0]      r_period, r_cnt;

  // STEPS shifts unrolled into a combinational chain.
  logic [STEPS:0][WIDTH-1:0] w_chain;
  assign w_chain[0] = r_state;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign w_chain[g+1] = shift1(w_chain[g]);
  end

  logic             w_zero, w_ld_zero, w_adv, w_hit;
  logic [WIDTH-1:0] w_next, w_ld;
  logic [31:0]      w_cnt_inc;

  assign w_zero    = (w_chain[STEPS] == '0);
  assign w_next    = w_zero ? ONE : w_chain[STEPS];
  assign w_ld_zero = (i_load_data == '0);
  assign w_ld      = w_ld_zero ? ONE : i_load_data;
  // A stalled word (valid, not ready) blocks advancing even with en high.
  assign w_adv     = i_en && !i_load && (!r_vld || i_out_ready);
  assign w_hit     = (w_next == r_ref);
  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= SEED_R;
      r_ref    <= SEED_R;
      r_out    <= '0;
      r_vld    <= 1'b0;
      r_wrap   <= 1'b0;
      r_lock   <= 1'b0;
      r_period <= '0;
      r_cnt    <= '0;
    end else begin
      r_wrap <= 1'b0;
      r_lock <= 1'b0;
      if (i_load) begin
        // Pending word is discarded; count restarts without a wrap.
        r_state <= w_ld;
        r_ref   <= w_ld;
        r_vld   <= 1'b0;
        r_cnt   <= '0;
        r_lock  <= w_ld_zero;
      end else if (w_adv) begin
        r_state <= w_next;
        r_out   <= w_next;
        r_vld   <= 1'b1;
        r_lock  <= w_zero;
        if (w_hit) begin
          r_wrap   <= 1'b1;
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= w_cnt_inc;
        end
      end else if (r_vld && i_out_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out;
  assign o_out_valid = r_vld;
  assign o_wrap      = r_wrap;
  assign o_lockup    = r_lock;
  assign o_period    = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: four instances (16-bit Fibonacci, 16-bit
// Galois, 4-bit Fibonacci with STEPS=1 and STEPS=4) share one stimulus stream.
module tb_lfsr_gen;

  logic        clk, rst, en, load, rdy;
  logic [15:0] ld;

  logic [15:0] f_d, g_d;
  logic [3:0]  a_d, b_d;
  logic        f_v, g_v, a_v, b_v;
  logic        f_w, g_w, a_w, b_w;
  logic        f_l, g_l, a_l, b_l;
  logic [31:0] f_p, g_p, a_p, b_p;

  lfsr_gen u_fib (.i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_load_data(ld),
    .o_out_data(f_d), .o_out_valid(f_v), .i_out_ready(rdy), .o_wrap(f_w), .o_lockup(f_l), .o_period(f_p));

  lfsr_gen #(.MODE(1)) u_gal (.i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_load_data(ld),
    .o_out_data(g_d), .o_out_valid(g_v), .i_out_ready(rdy), .o_wrap(g_w), .o_lockup(g_l), .o_period(g_p));

  lfsr_gen #(.WIDTH(4), .TAPS(32'hC), .SEED(32'd1)) u_w4 (.i_clk(clk), .i_rst(rst), .i_en(en),
    .i_load(load), .i_load_data(ld[3:0]), .o_out_data(a_d), .o_out_valid(a_v), .i_out_ready(rdy),
    .o_wrap(a_w), .o_lockup(a_l), .o_period(a_p));

  lfsr_gen #(.WIDTH(4), .TAPS(32'hC), .SEED(32'd1), .STEPS(4)) u_w4s (.i_clk(clk), .i_rst(rst), .i_en(en),
    .i_load(load), .i_load_data(ld[3:0]), .o_out_data(b_d), .o_out_valid(b_v), .i_out_ready(rdy),
    .o_wrap(b_w), .o_lockup(b_l), .o_period(b_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        en, rdy, load;
    logic [15:0] ld;
    logic [15:0] efib, egal;
    logic [3:0]  ew4, ew4s;
    logic        evld, ewrap, elock;
    logic [31:0] eper;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, r, l, input logic [15:0] d, input logic [15:0] ef, eg,
                     input logic [3:0] e4, e4s, input logic ev, ew, el, input logic [31:0] ep);
    vec_t v;
    v.en = e; v.rdy = r; v.load = l; v.ld = d; v.efib = ef; v.egal = eg;
    v.ew4 = e4; v.ew4s = e4s; v.evld = ev; v.ewrap = ew; v.elock = el; v.eper = ep;
    tbl.push_back(v);
  endtask

  // Hand-computed sequences (index = word number after seed 1).
  logic [15:0] fib_w [0:18];
  logic [15:0] gal_w [0:18];
  logic [3:0]  w4_seq  [0:14];
  logic [3:0]  w4s_seq [0:14];

  initial begin
    fib_w = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
              16'h0100, 16'h0200, 16'h0400, 16'h0801, 16'h1002, 16'h2005, 16'h400B, 16'h8016,
              16'h002D, 16'h005A, 16'h00B4};
    gal_w = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
              16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000,
              16'h6801, 16'hD002, 16'hC805};
    w4_seq  = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    w4s_seq = '{4'h3, 4'h5, 4'hE, 4'h2, 4'h6, 4'hB, 4'hC, 4'h4, 4'hD, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF, 4'h1};

    // Free run, words 1..16.
    for (int k = 1; k <= 16; k++)
      add(1, 1, 0, 0, fib_w[k], gal_w[k], w4_seq[k % 15], w4s_seq[(k-1) % 15],
          1, (k == 15), 0, (k >= 15) ? 32'd15 : 32'd0);
    // Back-pressure: 5 stalled cycles, word 16 frozen.
    for (int k = 0; k < 5; k++)
      add(1, 0, 0, 0, fib_w[16], gal_w[16], w4_seq[1], w4s_seq[0], 1, 0, 0, 15);
    add(1, 1, 0, 0, fib_w[17], gal_w[17], w4_seq[2], w4s_seq[1], 1, 0, 0, 15);
    // Consume without advance: valid drops, data holds.
    add(0, 1, 0, 0, fib_w[17], gal_w[17], w4_seq[2], w4s_seq[1], 0, 0, 0, 15);
    add(1, 1, 0, 0, fib_w[18], gal_w[18], w4_seq[3], w4s_seq[2], 1, 0, 0, 15);
    // Load 0 with en/ready high: lockup, valid cleared, no wrap.
    add(1, 1, 1, 0, fib_w[18], gal_w[18], w4_seq[3], w4s_seq[2], 0, 0, 1, 15);
    // Restart from seed 1; wrap again after exactly 15 advances.
    for (int k = 1; k <= 15; k++)
      add(1, 1, 0, 0, fib_w[k], gal_w[k], w4_seq[k % 15], w4s_seq[(k-1) % 15], 1, (k == 15), 0, 15);
    // Load nonzero seed 4 together with en.
    add(1, 1, 1, 16'h0004, fib_w[15], gal_w[15], w4_seq[0], w4s_seq[14], 0, 0, 0, 15);
    add(1, 1, 0, 0, 16'h0008, 16'h0008, 4'h9, 4'hD, 1, 0, 0, 15);
  end

  initial begin
    int n;
    bit found;
    rst = 1'b0; en = 1'b0; load = 1'b0; rdy = 1'b0; ld = '0;
    #3;
    chk("rst data", {16'h0, f_d}, 32'h0);
    chk("rst valid", {31'h0, f_v}, 32'h0);
    chk("rst wrap", {31'h0, f_w}, 32'h0);
    chk("rst lockup", {31'h0, f_l}, 32'h0);
    chk("rst period", f_p, 32'h0);
    chk("rst w4 period", a_p, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      en = tbl[i].en; rdy = tbl[i].rdy; load = tbl[i].load; ld = tbl[i].ld;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d fib", i), {16'h0, f_d}, {16'h0, tbl[i].efib});
      chk($sformatf("r%0d gal", i), {16'h0, g_d}, {16'h0, tbl[i].egal});
      chk($sformatf("r%0d w4", i), {28'h0, a_d}, {28'h0, tbl[i].ew4});
      chk($sformatf("r%0d w4s", i), {28'h0, b_d}, {28'h0, tbl[i].ew4s});
      chk($sformatf("r%0d vld", i), {30'h0, f_v, b_v}, {30'h0, tbl[i].evld, tbl[i].evld});
      chk($sformatf("r%0d wrap", i), {30'h0, a_w, b_w}, {30'h0, tbl[i].ewrap, tbl[i].ewrap});
      chk($sformatf("r%0d fibwrap", i), {31'h0, f_w}, 32'h0);
      chk($sformatf("r%0d lock", i), {30'h0, f_l, a_l}, {30'h0, tbl[i].elock, tbl[i].elock});
      chk($sformatf("r%0d per4", i), a_p, tbl[i].eper);
      chk($sformatf("r%0d per4s", i), b_p, tbl[i].eper);
    end
    load = 1'b0;

    // Async reset in the middle of a stall.
    @(negedge clk);
    en = 1'b1; rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("stall vld", {31'h0, f_v}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst data", {16'h0, f_d}, 32'h0);
    chk("arst vld", {31'h0, f_v}, 32'h0);
    chk("arst w4 data", {28'h0, a_d}, 32'h0);
    chk("arst period", a_p, 32'h0);
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst fib", {16'h0, f_d}, 32'h0002);
    chk("post rst gal", {16'h0, g_d}, 32'h0002);
    chk("post rst w4", {28'h0, a_d}, 32'h2);
    chk("post rst w4s", {28'h0, b_d}, 32'h3);
    chk("post rst vld", {31'h0, f_v}, 32'h1);

    // Full-period run of the default polynomial (one advance already done).
    found = 1'b0;
    n = 1;
    while (n < 70000 && !found) begin
      @(posedge clk);
      #1;
      n++;
      if (f_w) found = 1'b1;
    end
    chk("wrap seen", {31'h0, found}, 32'h1);
    chk("wrap advance", n, 32'd65535);
    chk("fib period", f_p, 32'd65535);
    chk("wrap word", {16'h0, f_d}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator; successor to the fixed 16-bit LFSR used for LMS stimulus and noise injection. Width, tap polynomial, Fibonacci/Galois form and shifts-per-output are compile-time parameters. Runtime features: seed loading with zero-lockup protection, a one-deep valid/ready output register for back-pressured consumers, and period measurement with a wrap strobe.

## Interface
- WIDTH, 16: state/output width, legal 3..32.
- TAPS, 16'hB400: polynomial mask; bit i set means term x^(i+1), x^0 implicit. Default is x^16+x^14+x^13+x^11+1.
- SEED, 1: reset seed; 0 is replaced by 1.
- STEPS, 1: LFSR shifts per output word, legal 1..WIDTH.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  request new words.
- load  in  1  load seed this cycle.
- load_data  in  WIDTH  seed value.
- out_data  out  WIDTH  registered sequence word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data.
- wrap  out  1  one-cycle strobe: sequence returned to reference seed.
- lockup  out  1  one-cycle strobe: all-zero state replaced by 1.
- period  out  32  advances between the last two wraps.

## Operation
- Fibonacci shift: fb = XOR of state[i] for all i where TAPS[i] = 1; state <= {state[WIDTH-2:0], fb}.
- Galois shift: msb = state[WIDTH-1]; state <= {state[WIDTH-2:0], 0} XOR (msb ? {TAPS[WIDTH-2:0], 1} : 0).
- next = STEPS shifts applied combinationally to state in one cycle.
- Advance condition: en && !load && (!out_valid || out_ready).
  - On advance: state <= next; out_data <= next; out_valid <= 1.
- Consumption without advance: out_valid && out_ready && !advance clears out_valid. out_data holds its value.
- Stall: out_valid && !out_ready. state and out_data hold, and en is ignored.
- Zero guard: if next == 0 (or load_data == 0 on load), substitute 1 and pulse lockup.
- Load has priority over advance.
  - state <= load_data (after zero guard); ref_seed <= same value.
  - out_valid <= 0; any pending word is discarded.
  - adv_cnt <= 0. No wrap is generated on the load cycle.
- Wrap detection on each advance:
  - If next == ref_seed: wrap pulses, period <= adv_cnt + 1, adv_cnt <= 0.
  - Otherwise adv_cnt increments, saturating at 32'hFFFFFFFF.
  - With STEPS > 1, wrap is checked only at output boundaries.

## Timing
- Reset values: state = ref_seed = SEED (1 if SEED == 0); out_data = 0; out_valid = 0; wrap = 0; lockup = 0; period = 0; adv_cnt = 0.
- Reset asserts asynchronously. Deassertion is synchronised upstream; the first advance can occur on the first edge after deassertion.
- Latency: en high at edge k gives the new out_data/out_valid immediately after edge k.
- Throughput: one word per cycle while en and out_ready are held high.
- wrap, lockup and period update on the same edge as the triggering advance or load.
- Simultaneous load, en and out_ready: load wins, out_valid = 0 next cycle, and the sequence restarts from the loaded seed on the following advance.
- rst asserted mid-stall: the pending word is lost and out_valid = 0.

## Test plan
- Defaults, Fibonacci, en and out_ready held high after reset:
  - First words: 0x0002, 0x0004, 0x0008.
  - Word 11 (0x0400 -> next) = 0x0801.
  - First wrap after 65535 advances; period = 65535.
- MODE=1, defaults: words 0x0002 ... 0x8000 (words 1-15), then word 16 = 0x6801.
- WIDTH=4, TAPS=4'b1100, Fibonacci, seed 1:
  - Sequence 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - wrap on word 15; period = 15.
  - Repeat with STEPS=4: wrap after 15 advances.
- Back-pressure: out_ready low for 5 cycles with en high.
  - out_data frozen and out_valid = 1 throughout.
  - On ready release, the next word follows without a skip or duplicate.
- Load 0 with en high:
  - lockup pulses once; out_valid = 0 next cycle.
  - Next word = 0x0002 (default polynomial); adv_cnt restarts from 0.
- Async reset asserted mid-stream between edges:
  - Outputs go to reset values immediately.
  - Sequence restarts at 0x0002 after release.
